// File: rtl/rgb_hdown2.sv
// Horizontal 2:1 RGB downscaler: averages adjacent pixel pairs within a de-framed
// line, flushes a trailing odd pixel, and reports output index and end-of-line.
module rgb_hdown2 #(
    parameter int WIDTH  = 10,
    parameter int HCNT_W = 12
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              i_de,
    input  logic [WIDTH-1:0]  i_r,
    input  logic [WIDTH-1:0]  i_g,
    input  logic [WIDTH-1:0]  i_b,
    output logic              o_de,
    output logic [WIDTH-1:0]  o_r,
    output logic [WIDTH-1:0]  o_g,
    output logic [WIDTH-1:0]  o_b,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic              o_eol
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    hold_r_q, hold_r_d;
    logic [WIDTH-1:0]    hold_g_q, hold_g_d;
    logic [WIDTH-1:0]    hold_b_q, hold_b_d;
    logic                prev_de_q, prev_de_d;
    logic [HCNT_W-1:0]   cnt_q, cnt_d;

    logic                de_q, de_d;
    logic                eol_q, eol_d;
    logic [WIDTH-1:0]    r_q, r_d;
    logic [WIDTH-1:0]    g_q, g_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;

    // Round-half-up average; the carry bit of the WIDTH+1 sum is kept so nothing overflows.
    function automatic logic [WIDTH-1:0] avg(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
        return sum[WIDTH:1];
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (!rstn) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (i_de) state_d = HOLD;
            HOLD:  state_d = EMPTY;
        endcase
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        hold_r_d  = hold_r_q;
        hold_g_d  = hold_g_q;
        hold_b_d  = hold_b_q;
        prev_de_d = i_de;
        cnt_d     = cnt_q;
        de_d      = 1'b0;
        eol_d     = 1'b0;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hcnt_d    = hcnt_q;

        case (state_q)
            EMPTY: begin
                if (i_de) begin
                    hold_r_d = i_r;
                    hold_g_d = i_g;
                    hold_b_d = i_b;
                end else if (prev_de_q) begin
                    eol_d = 1'b1;
                end
            end
            HOLD: begin
                de_d = 1'b1;
                if (i_de) begin
                    r_d = avg(hold_r_q, i_r);
                    g_d = avg(hold_g_q, i_g);
                    b_d = avg(hold_b_q, i_b);
                end else begin
                    eol_d = 1'b1;
                    r_d   = hold_r_q;
                    g_d   = hold_g_q;
                    b_d   = hold_b_q;
                end
            end
        endcase

        // The index reported with a pixel is the pre-increment count; eol restarts the line.
        if (de_d) begin
            hcnt_d = cnt_q;
            cnt_d  = cnt_q + HCNT_W'(1);
        end
        if (eol_d) cnt_d = '0;
    end

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            hold_r_q  <= '0;
            hold_g_q  <= '0;
            hold_b_q  <= '0;
            prev_de_q <= 1'b0;
            cnt_q     <= '0;
            de_q      <= 1'b0;
            eol_q     <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hcnt_q    <= '0;
        end else begin
            hold_r_q  <= hold_r_d;
            hold_g_q  <= hold_g_d;
            hold_b_q  <= hold_b_d;
            prev_de_q <= prev_de_d;
            cnt_q     <= cnt_d;
            de_q      <= de_d;
            eol_q     <= eol_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign o_de   = de_q;
    assign o_eol  = eol_q;
    assign o_r    = r_q;
    assign o_g    = g_q;
    assign o_b    = b_q;
    assign o_hcnt = hcnt_q;

endmodule

// File: tb/tb_rgb_hdown2.sv
// Self-checking bench for rgb_hdown2: directed line shapes plus long random lines,
// compared cycle by cycle against a line-buffer reference model.
module tb_rgb_hdown2;

    localparam int WIDTH  = 10;
    localparam int HCNT_W = 12;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] b;
    } px_t;

    logic              pclk = 1'b0;
    logic              rstn;
    logic              i_de;
    logic [WIDTH-1:0]  i_r, i_g, i_b;
    logic              o_de;
    logic [WIDTH-1:0]  o_r, o_g, o_b;
    logic [HCNT_W-1:0] o_hcnt;
    logic              o_eol;

    rgb_hdown2 #(.WIDTH(WIDTH), .HCNT_W(HCNT_W)) dut (
        .pclk   (pclk),
        .rstn   (rstn),
        .i_de   (i_de),
        .i_r    (i_r),
        .i_g    (i_g),
        .i_b    (i_b),
        .o_de   (o_de),
        .o_r    (o_r),
        .o_g    (o_g),
        .o_b    (o_b),
        .o_hcnt (o_hcnt),
        .o_eol  (o_eol)
    );

    always #5 pclk = ~pclk;

    int  n_checks = 0;
    int  n_errors = 0;
    px_t line_q[$];
    int  out_idx = 0;
    px_t last_px = '0;
    int  got_de_total = 0;
    int  got_eol_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic px_t avg_px(input px_t a, input px_t b);
        px_t p;
        p.r = WIDTH'((int'(a.r) + int'(b.r) + 1) / 2);
        p.g = WIDTH'((int'(a.g) + int'(b.g) + 1) / 2);
        p.b = WIDTH'((int'(a.b) + int'(b.b) + 1) / 2);
        return p;
    endfunction

    function automatic px_t rand_px();
        px_t p;
        p.r = WIDTH'($urandom);
        p.g = WIDTH'($urandom);
        p.b = WIDTH'($urandom);
        return p;
    endfunction

    function automatic px_t gray(input int v);
        px_t p;
        p.r = WIDTH'(v);
        p.g = WIDTH'(v);
        p.b = WIDTH'(v);
        return p;
    endfunction

    // One pixel clock: present inputs, predict the registered outputs, sample #1 after the edge.
    task automatic step(input logic rst_v, input logic de, input px_t p);
        logic e_de, e_eol;
        px_t  e_px;
        int   e_hcnt;
        rstn = rst_v;
        i_de = de;
        i_r  = p.r;
        i_g  = p.g;
        i_b  = p.b;

        e_de   = 1'b0;
        e_eol  = 1'b0;
        e_hcnt = -1;
        if (!rst_v) begin
            line_q.delete();
            out_idx = 0;
            last_px = '0;
            e_hcnt  = 0;
        end else if (de) begin
            line_q.push_back(p);
            if (line_q.size() % 2 == 0) begin
                e_de    = 1'b1;
                last_px = avg_px(line_q[line_q.size()-2], line_q[line_q.size()-1]);
                e_hcnt  = out_idx % (1 << HCNT_W);
                out_idx++;
            end
        end else if (line_q.size() > 0) begin
            e_eol = 1'b1;
            if (line_q.size() % 2 == 1) begin
                e_de    = 1'b1;
                last_px = line_q[line_q.size()-1];
                e_hcnt  = out_idx % (1 << HCNT_W);
            end
            line_q.delete();
            out_idx = 0;
        end
        e_px = last_px;

        @(posedge pclk);
        #1;
        if (o_de === 1'b1)  got_de_total++;
        if (o_eol === 1'b1) got_eol_total++;
        check("o_de", 32'(o_de), 32'(e_de));
        check("o_eol", 32'(o_eol), 32'(e_eol));
        check("o_r", 32'(o_r), 32'(e_px.r));
        check("o_g", 32'(o_g), 32'(e_px.g));
        check("o_b", 32'(o_b), 32'(e_px.b));
        if (e_hcnt >= 0) check("o_hcnt", 32'(o_hcnt), 32'(e_hcnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rand_px());
    endtask

    task automatic rand_line(input int len, input int gap);
        for (int i = 0; i < len; i++) step(1'b1, 1'b1, rand_px());
        idle(gap);
    endtask

    initial begin
        int   exp_de_total;
        int   exp_eol_total;
        int   len;
        int   even_vals[4] = '{0, 2, 1023, 1022};
        int   odd_vals[3]  = '{10, 11, 500};

        // Reset with random activity on the inputs.
        step(1'b0, 1'($urandom), rand_px());
        step(1'b0, 1'($urandom), rand_px());
        idle(2);

        // Even line with a tie that must round up to full scale.
        foreach (even_vals[i]) step(1'b1, 1'b1, gray(even_vals[i]));
        idle(3);

        // Odd line: pair then flushed trailing pixel with eol on the same cycle.
        foreach (odd_vals[i]) step(1'b1, 1'b1, gray(odd_vals[i]));
        idle(2);

        // Back-to-back odd lines separated by a single idle cycle.
        rand_line(3, 1);
        rand_line(5, 1);
        rand_line(1, 1);
        rand_line(2, 1);
        idle(2);

        // Reset while a pixel is held: no flush, no eol, next pair starts at index 0.
        step(1'b1, 1'b1, rand_px());
        step(1'b0, 1'b1, rand_px());
        idle(3);
        rand_line(2, 2);
        step(1'b1, 1'b1, rand_px());
        step(1'b0, 1'b0, rand_px());
        idle(2);

        // Long random lines; totals must match ceil(len/2) pixels and one eol per line.
        got_de_total  = 0;
        got_eol_total = 0;
        exp_de_total  = 0;
        exp_eol_total = 0;
        for (int l = 0; l < 12; l++) begin
            len = (l < 2) ? l + 1 : int'($urandom_range(1, 2000));
            exp_de_total  += (len + 1) / 2;
            exp_eol_total += 1;
            rand_line(len, int'($urandom_range(1, 4)));
        end
        idle(2);
        check("random_pixel_total", 32'(got_de_total), 32'(exp_de_total));
        check("random_eol_total", 32'(got_eol_total), 32'(exp_eol_total));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
